// File: rtl/ram_dump_engine_pkg.sv
// Shared types for the RAM dump engine: RAM handshake states, word type and
// the dump sequencer states.
package ram_dump_engine_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    READ  = 3'd2,
    RETRY = 3'd3,
    EMIT  = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } dump_state_t;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic word_t word_addr(input word_t base, input word_t idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/ram_dump_engine_stream_reg.sv
// Single-entry valid/ready holding register for emitted dump words.
// Address and data stay stable while valid is high and the consumer stalls.
module dump_stream_reg
  import ram_dump_engine_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  load_i,
  input  word_t addr_i,
  input  word_t data_i,
  input  logic  ready_i,
  output logic  valid_o,
  output word_t addr_o,
  output word_t data_o
);

  logic  valid_q, valid_d;
  word_t addr_q, addr_d;
  word_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      addr_d  = '0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ram_dump_engine.sv
// Post-halt RAM dump initiator: takes RAM ownership, reads WORDS words from
// BASE, streams non-skipped words out and keeps a running checksum.
module ram_dump_engine
  import ram_dump_engine_pkg::*;
#(
  parameter int          WORDS     = 16384,
  parameter logic [31:0] BASE      = 32'h0,
  parameter int          SKIP_ZERO = 1,
  parameter int          MAX_RETRY = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        halt,
  output logic        tb_ctrl,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic [1:0]  ram_state,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  dump_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  word_t            cks_q, cks_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             emit_load, flush;
  ramstate_t        rs_w;
  word_t            addr_w;

  assign rs_w   = ramstate_t'(ram_state);
  assign addr_w = word_addr(BASE, 32'(idx_q));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    cks_d     = cks_q;
    done_d    = done_q;
    err_d     = err_q;
    emit_load = 1'b0;
    flush     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ARM;
          idx_d   = '0;
          retry_d = '0;
          cks_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          flush   = 1'b1;
        end
      end
      ARM: begin
        if (halt) state_d = READ;
      end
      READ: begin
        case (rs_w)
          ACCESS: begin
            // Zero words still count toward the checksum even when skipped.
            cks_d = cks_q + ram_load;
            if ((SKIP_ZERO != 0) && (ram_load == 32'h0)) begin
              state_d = NEXT;
            end else begin
              emit_load = 1'b1;
              state_d   = EMIT;
            end
          end
          ERROR: begin
            if (32'(retry_q) + 32'd1 >= 32'(MAX_RETRY)) begin
              state_d = DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end else begin
              retry_d = retry_q + RTY_W'(1);
              state_d = RETRY;
            end
          end
          default: ;
        endcase
      end
      RETRY: state_d = READ;
      EMIT: begin
        if (out_valid && out_ready) state_d = NEXT;
      end
      NEXT: begin
        retry_d = '0;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      cks_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      cks_q   <= cks_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  dump_stream_reg u_stream (
    .clk     (CLK),
    .rst_n   (nRST),
    .clr_i   (flush),
    .load_i  (emit_load),
    .addr_i  (addr_w),
    .data_i  (ram_load),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .addr_o  (out_addr),
    .data_o  (out_data)
  );

  // Moore decode so reset drops every control output immediately.
  assign tb_ctrl   = (state_q == READ) || (state_q == RETRY) ||
                     (state_q == EMIT) || (state_q == NEXT);
  assign ram_ren   = (state_q == READ);
  assign ram_addr  = tb_ctrl ? addr_w : 32'h0;
  assign ram_wen   = 1'b0;
  assign ram_store = 32'h0;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = cks_q;

endmodule

// File: tb/tb_ram_dump_engine.sv
// Bench for ram_dump_engine: two 4-word instances (no skip / zero skip), a
// behavioural RAM responder with latency and error injection, and a
// scoreboard of expected stream transfers.
module tb_ram_dump_engine;
  import ram_dump_engine_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [1:0]  start;
  logic        halt, out_ready;
  logic [1:0]  tb_ctrl, ren, wen, ov, busy, done, err;
  logic [31:0] raddr[2], store[2], load[2], oaddr[2], odata[2], cks[2];
  logic [1:0]  rs[2];

  logic [3:0][31:0] mem;
  int lat, ew, ecnt;
  int wcnt[2], egiven[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_dump_engine #(.WORDS(4), .BASE(32'h0), .SKIP_ZERO(g), .MAX_RETRY(3)) u_dut (
      .CLK(CLK), .nRST(nRST), .start(start[g]), .halt(halt),
      .tb_ctrl(tb_ctrl[g]), .ram_ren(ren[g]), .ram_wen(wen[g]),
      .ram_addr(raddr[g]), .ram_store(store[g]), .ram_load(load[g]),
      .ram_state(rs[g]), .out_valid(ov[g]), .out_ready(out_ready),
      .out_addr(oaddr[g]), .out_data(odata[g]), .busy(busy[g]),
      .done(done[g]), .err(err[g]), .checksum(cks[g]));
    assign load[g] = mem[raddr[g][3:2]];
    assign rs[g] = !ren[g] ? FREE :
                   (wcnt[g] < lat) ? BUSY :
                   (32'(raddr[g][3:2]) == ew && egiven[g] < ecnt) ? ERROR : ACCESS;
  end

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (start[k]) begin
        wcnt[k]   <= 0;
        egiven[k] <= 0;
      end else if (ren[k]) begin
        if (rs[k] == BUSY) wcnt[k] <= wcnt[k] + 1;
        else begin
          wcnt[k] <= 0;
          if (rs[k] == ERROR) egiven[k] <= egiven[k] + 1;
        end
      end
    end
  end

  typedef struct { logic [31:0] a; logic [31:0] d; } xfer_t;
  xfer_t q[$];
  int checks = 0, errors = 0, nx = 0;

  typedef struct {
    int               dut;
    logic [3:0][31:0] m;
    int               lt, ewd, ec;
    logic [31:0]      cks;
    logic             e;
    int               nx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (ov[k] && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_xfer dut%0d addr %h data %h exp none", k, oaddr[k], odata[k]);
        end else begin
          xfer_t x;
          x = q.pop_front();
          chk("xfer_addr", oaddr[k], x.a);
          chk("xfer_data", odata[k], x.d);
          nx++;
        end
      end
      chk("wen_store", {31'd0, wen[k]} | store[k], 32'h0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic push_exp(input int k);
    for (int w = 0; w < 4; w++) begin
      if (ew == w && ecnt >= 3) break;
      if (!(k == 1 && mem[w] == 32'h0)) q.push_back('{32'(w * 4), mem[w]});
    end
  endtask

  task automatic kick(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int i = 0;
    while (!done[k] && i < 300) begin tick(); i++; end
    if (!done[k]) begin
      checks++; errors++;
      $display("FAIL timeout_done dut%0d got 0 exp 1", k);
    end
  endtask

  task automatic wait_valid(input int k);
    int i = 0;
    while (!ov[k] && i < 100) begin tick(); i++; end
    if (!ov[k]) begin
      checks++; errors++;
      $display("FAIL timeout_valid dut%0d got 0 exp 1", k);
    end
  endtask

  task automatic setup(input logic [3:0][31:0] m, input int lt, input int e_w, input int e_c, input int k);
    mem = m; lat = lt; ew = e_w; ecnt = e_c;
    q.delete(); nx = 0;
    push_exp(k);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{dut:0, m:{32'd4, 32'd3, 32'd2, 32'd1}, lt:2, ewd:0, ec:0, cks:32'd10, e:1'b0, nx:4};
    vecs[1] = '{dut:1, m:{32'd7, 32'd0, 32'd5, 32'd0}, lt:0, ewd:0, ec:0, cks:32'd12, e:1'b0, nx:2};
    vecs[2] = '{dut:0, m:{32'd40, 32'd30, 32'd20, 32'd10}, lt:1, ewd:1, ec:1, cks:32'd100, e:1'b0, nx:4};
    vecs[3] = '{dut:0, m:{32'd4, 32'd3, 32'd2, 32'd1}, lt:0, ewd:2, ec:3, cks:32'd3, e:1'b1, nx:2};
    vecs[4] = '{dut:1, m:{32'd0, 32'd2, 32'd0, 32'hFFFF_FFFF}, lt:0, ewd:0, ec:0, cks:32'd1, e:1'b0, nx:2};
    vecs[5] = '{dut:1, m:{32'd0, 32'd0, 32'd0, 32'd0}, lt:0, ewd:0, ec:0, cks:32'd0, e:1'b0, nx:0};

    start = 2'b00; halt = 1'b0; out_ready = 1'b0; nRST = 1'b0;
    mem = '0; lat = 0; ew = 0; ecnt = 0;
    #23;
    for (int k = 0; k < 2; k++) begin
      chk("reset_ctl", {25'd0, tb_ctrl[k], ren[k], wen[k], ov[k], busy[k], done[k], err[k]}, 32'h0);
      chk("reset_cks", cks[k], 32'h0);
      chk("reset_oaddr", oaddr[k] | odata[k] | raddr[k], 32'h0);
    end
    nRST = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      setup(vecs[i].m, vecs[i].lt, vecs[i].ewd, vecs[i].ec, vecs[i].dut);
      out_ready = 1'b1; halt = 1'b1;
      kick(vecs[i].dut);
      wait_done(vecs[i].dut);
      chk("cks", cks[vecs[i].dut], vecs[i].cks);
      chk("done", {31'd0, done[vecs[i].dut]}, 32'd1);
      chk("err", {31'd0, err[vecs[i].dut]}, {31'd0, vecs[i].e});
      chk("idle_ctl", {30'd0, tb_ctrl[vecs[i].dut], busy[vecs[i].dut]}, 32'h0);
      tick();
      chk("nxfer", nx, vecs[i].nx);
      chk("q_empty", q.size(), 0);
    end

    // Halt gating: nothing touches RAM until halt, then READ on the next cycle.
    setup({32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 0, 0);
    halt = 1'b0; out_ready = 1'b1;
    kick(0);
    for (int i = 0; i < 20; i++) begin
      chk("gate", {30'd0, tb_ctrl[0], ren[0]}, 32'h0);
      tick();
    end
    halt = 1'b1;
    chk("gate_edge", {30'd0, tb_ctrl[0], ren[0]}, 32'h0);
    tick();
    halt = 1'b0;
    chk("gate_read", {30'd0, tb_ctrl[0], ren[0]}, 32'h3);
    wait_done(0);
    chk("gate_cks", cks[0], 32'd10);
    chk("gate_nx", nx, 4);

    // Backpressure on the first word.
    setup({32'd40, 32'd30, 32'd20, 32'd10}, 0, 0, 0, 0);
    halt = 1'b1; out_ready = 1'b0;
    kick(0);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, ov[0]}, 32'd1);
      chk("bp_addr", oaddr[0], q[0].a);
      chk("bp_data", odata[0], q[0].d);
      chk("bp_ren", {31'd0, ren[0]}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_done(0);
    chk("bp_cks", cks[0], 32'd100);
    chk("bp_nx", nx, 4);
    chk("bp_q", q.size(), 0);

    // Reset mid-dump, then a fresh full dump.
    setup({32'd40, 32'd30, 32'd20, 32'd10}, 0, 0, 0, 0);
    out_ready = 1'b0;
    kick(0);
    wait_valid(0);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_ctl", {25'd0, tb_ctrl[0], ren[0], wen[0], ov[0], busy[0], done[0], err[0]}, 32'h0);
    chk("mid_rst_cks", cks[0], 32'h0);
    chk("mid_rst_out", oaddr[0] | odata[0] | raddr[0], 32'h0);
    #10 nRST = 1'b1;
    @(posedge CLK); #1;
    setup({32'd40, 32'd30, 32'd20, 32'd10}, 0, 0, 0, 0);
    out_ready = 1'b1;
    kick(0);
    wait_done(0);
    chk("fresh_cks", cks[0], 32'd100);
    chk("fresh_nx", nx, 4);
    chk("fresh_err", {31'd0, err[0]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
